// File: rtl/baccarat_pkg.sv
// Shared baccarat types and constants.
// Used by the deal sequencer and its draw-rule helper.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_EVAL,
    S_P3,
    S_DDEC,
    S_D3,
    S_RESULT
  } state_t;

  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
  localparam logic [3:0] DEALER_DRAW_MAX = 4'd5;

  // Face cards and tens count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] c);
    return (c <= 4'd9) ? c : 4'd0;
  endfunction

endpackage

// File: rtl/dealer_draw_rule.sv
// Dealer third-card decision once the player has drawn.
// Purely combinational.
module dealer_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] w_v;

  assign w_v = card_value(pcard3);

  always_comb begin
    draw = 1'b0;
    unique case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3: draw = (w_v != 4'd8);
      4'd4: draw = (w_v >= 4'd2) && (w_v <= 4'd7);
      4'd5: draw = (w_v >= 4'd4) && (w_v <= 4'd7);
      4'd6: draw = (w_v >= 4'd6) && (w_v <= 4'd7);
      default: draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat hand sequencer: deals cards, applies draw rules,
// registers the result lights.
module deal_sequencer
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       step,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
);

  state_t r_state;
  logic   r_pwin;
  logic   r_dwin;
  logic   r_done;
  logic   w_draw;
  logic   w_natural;
  logic   w_go;

  dealer_draw_rule u_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (w_draw)
  );

  assign w_natural = (pscore >= NATURAL_MIN) ||
                     (dscore >= NATURAL_MIN);

  // Strobes are gated by reset so a held step cannot leak a load.
  assign w_go = step & resetb;

  assign load_pcard1 = w_go && (r_state == S_P1);
  assign load_dcard1 = w_go && (r_state == S_D1);
  assign load_pcard2 = w_go && (r_state == S_P2);
  assign load_dcard2 = w_go && (r_state == S_D2);
  assign load_pcard3 = w_go && (r_state == S_P3);
  assign load_dcard3 = w_go && (r_state == S_D3);

  assign player_win_light = r_pwin;
  assign dealer_win_light = r_dwin;
  assign done             = r_done;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_P1;
      r_pwin  <= 1'b0;
      r_dwin  <= 1'b0;
      r_done  <= 1'b0;
    end else if (step) begin
      unique case (r_state)
        S_P1: r_state <= S_D1;
        S_D1: r_state <= S_P2;
        S_P2: r_state <= S_D2;
        S_D2: r_state <= S_EVAL;
        S_EVAL: begin
          if (w_natural)
            r_state <= S_RESULT;
          else if (pscore <= PLAYER_DRAW_MAX)
            r_state <= S_P3;
          else if (dscore <= DEALER_DRAW_MAX)
            r_state <= S_D3;
          else
            r_state <= S_RESULT;
        end
        S_P3:   r_state <= S_DDEC;
        S_DDEC: r_state <= w_draw ? S_D3 : S_RESULT;
        S_D3:   r_state <= S_RESULT;
        S_RESULT: begin
          if (!r_done) begin
            r_pwin <= (pscore >= dscore);
            r_dwin <= (dscore >= pscore);
            r_done <= 1'b1;
          end
        end
        default: r_state <= S_P1;
      endcase
    end
  end

endmodule
